// File: rtl/neuro_pkg.sv
// Shared definitions for the neuron datapath blocks: default widths,
// writeback FSM state encoding and saturation limit helpers.
package neuro_pkg;

   localparam int ACC_W_DEF  = 16;
   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } wb_state_t;

   // Largest value representable in a w-bit two's complement word.
   function automatic int sat_hi(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   // Smallest value representable in a w-bit two's complement word.
   function automatic int sat_lo(input int w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/neuron_writeback_if.sv
// Accumulator stream (valid/ready) and neuron RAM write port of the
// writeback block. master = producer/RAM side, slave = neuron_writeback.
interface neuron_writeback_if
   import neuro_pkg::*;
#(
   parameter int ACC_W  = ACC_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);

   logic              acc_valid;
   logic              acc_ready;
   logic [ACC_W-1:0]  acc_data;
   logic              mem_stall;
   logic              mem_wre;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;

   modport master (
      output acc_valid, acc_data, mem_stall,
      input  acc_ready, mem_wre, mem_addr, mem_data
   );

   modport slave (
      input  acc_valid, acc_data, mem_stall,
      output acc_ready, mem_wre, mem_addr, mem_data
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head. DEPTH must be a
// power of two so the pointers wrap naturally. A push while full is taken
// only when a pop happens in the same cycle; a pop while empty is ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || pop);
   assign dout    = mem[rd_ptr];

   // Storage write.
   // NOTE: the storage array is deliberately left out of reset; the pointers
   // and count define validity, and an unreset array maps onto plain RAM/regs.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy bookkeeping, flushed by reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/neuron_writeback.sv
// Neuron writeback: accepts MAC accumulator results, rescales them by an
// arithmetic right shift, saturates to DATA_W, optionally applies ReLU,
// buffers them in a small FIFO and writes them to the neuron RAM at
// consecutive (wrapping) addresses from a base. Pulses done after the
// programmed number of writes.
// Build option: define NEURON_WB_RELU_EN to write negative results as 0.
module neuron_writeback
   import neuro_pkg::*;
#(
   parameter int ACC_W      = ACC_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int FIFO_DEPTH = 4,
   parameter int FRAC_SHIFT = 4
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] count,
   neuron_writeback_if.slave bus,
   output logic              busy,
   output logic              done,
   output logic              sat_flag
);

`ifdef NEURON_WB_RELU_EN
   localparam bit RELU_EN = 1'b1;
`else
   localparam bit RELU_EN = 1'b0;
`endif

   // Clamp limits expressed at accumulator width for a signed compare.
   localparam logic signed [ACC_W-1:0] SAT_HI_A = ACC_W'(sat_hi(DATA_W));
   localparam logic signed [ACC_W-1:0] SAT_LO_A = ACC_W'(sat_lo(DATA_W));

   wb_state_t               state;
   wb_state_t               state_next;
   logic [ADDR_W-1:0]       base_q;
   logic [ADDR_W-1:0]       count_q;
   logic [ADDR_W-1:0]       accepted_q;
   logic [ADDR_W-1:0]       written_q;
   logic                    start_ok;
   logic                    push;
   logic                    pop;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    sat_hit;
   logic signed [ACC_W-1:0] shifted;
   logic [DATA_W-1:0]       conv_data;
   logic [DATA_W-1:0]       fifo_head;

   assign start_ok = start && (state == IDLE);
   assign push     = bus.acc_valid && bus.acc_ready;
   assign pop      = !fifo_empty && !bus.mem_stall;

   // Rescale, clamp and optionally rectify the incoming accumulator value.
   always_comb begin
      shifted   = $signed(bus.acc_data) >>> FRAC_SHIFT;
      sat_hit   = 1'b0;
      conv_data = shifted[DATA_W-1:0];
      if (shifted > SAT_HI_A) begin
         conv_data = SAT_HI_A[DATA_W-1:0];
         sat_hit   = 1'b1;
      end else if (shifted < SAT_LO_A) begin
         conv_data = SAT_LO_A[DATA_W-1:0];
         sat_hit   = 1'b1;
      end
      if (RELU_EN && conv_data[DATA_W-1]) begin
         conv_data = '0;
      end
   end

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (conv_data),
      .pop   (pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next state and state-decoded outputs.
   // NOTE: every output of this block gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      state_next    = state;
      bus.acc_ready = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (count == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            busy          = 1'b1;
            bus.acc_ready = !fifo_full && (accepted_q < count_q);
            if (written_q == count_q) begin
               state_next = DONE;
            end
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Layer parameters and accepted/written counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         base_q     <= '0;
         count_q    <= '0;
         accepted_q <= '0;
         written_q  <= '0;
      end else if (start_ok) begin
         base_q     <= base_addr;
         count_q    <= count;
         accepted_q <= '0;
         written_q  <= '0;
      end else begin
         if (push) begin
            accepted_q <= accepted_q + ADDR_W'(1);
         end
         if (pop) begin
            written_q <= written_q + ADDR_W'(1);
         end
      end
   end

   // Sticky saturation flag, cleared when a new layer starts.
   always_ff @(posedge clk) begin
      if (reset) begin
         sat_flag <= 1'b0;
      end else if (start_ok) begin
         sat_flag <= 1'b0;
      end else if (push && sat_hit) begin
         sat_flag <= 1'b1;
      end
   end

   // Registered RAM write port; address and data hold when nothing pops.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.mem_wre  <= 1'b0;
         bus.mem_addr <= '0;
         bus.mem_data <= '0;
      end else begin
         bus.mem_wre <= pop;
         if (pop) begin
            bus.mem_addr <= base_q + written_q;
            bus.mem_data <= fifo_head;
         end
      end
   end

endmodule

// File: tb/tb_neuron_writeback.sv
// Scoreboard bench for neuron_writeback: the stimulus pushes the expected
// (address, data) pairs of each layer into a queue and a monitor pops and
// compares them whenever the DUT asserts mem_wre.
module tb_neuron_writeback;

   localparam int ACC_W  = 16;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 8;

`ifdef NEURON_WB_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] base_addr;
   logic [7:0] count;
   logic       busy;
   logic       done;
   logic       sat_flag;

   neuron_writeback_if #(.ACC_W(ACC_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   neuron_writeback #(
      .ACC_W      (ACC_W),
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .FIFO_DEPTH (4),
      .FRAC_SHIFT (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .count     (count),
      .bus       (bus.slave),
      .busy      (busy),
      .done      (done),
      .sat_flag  (sat_flag)
   );

   always #5 clk = ~clk;

   wr_t         exp_q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          wr_total = 0;
   int          done_total = 0;
   int          last_wr_cyc = 0;
   int          done_cyc = 0;
   int          start_cyc = 0;
   int          wr0 = 0;
   int          done0 = 0;
   logic [15:0] vec [8];
   logic [7:0]  expv [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   function automatic logic [7:0] neg(input logic [7:0] v);
      return RELU ? 8'h00 : v;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares every RAM write against the scoreboard head.
   always @(negedge clk) begin
      wr_t e;
      if (reset) begin
         exp_q.delete();
      end else begin
         if (bus.mem_wre) begin
            wr_total++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("spurious write", bus.mem_wre, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("write addr", bus.mem_addr, e.addr);
               check("write data", bus.mem_data, e.data);
            end
         end
         if (done) begin
            done_total++;
            done_cyc = cyc;
         end
      end
   end

   task automatic check_reset_outputs();
      check("rst acc_ready", bus.acc_ready, 1'b0);
      check("rst mem_wre", bus.mem_wre, 1'b0);
      check("rst mem_addr", bus.mem_addr, 8'h00);
      check("rst mem_data", bus.mem_data, 8'h00);
      check("rst busy", busy, 1'b0);
      check("rst done", done, 1'b0);
      check("rst sat_flag", sat_flag, 1'b0);
   endtask

   task automatic start_layer(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{addr: 8'(b + 8'(i)), data: expv[i]});
      end
      wr0       = wr_total;
      done0     = done_total;
      base_addr = b;
      count     = 8'(n);
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic feed_vals(input int first, input int last);
      for (int i = first; i < last; i++) begin
         bit got = 1'b0;
         bus.acc_valid = 1'b1;
         bus.acc_data  = vec[i];
         for (int t = 0; t < 100 && !got; t++) begin
            got = bus.acc_ready;
            @(posedge clk); #1;
         end
         check("sample accepted", got, 1'b1);
      end
      bus.acc_valid = 1'b0;
   endtask

   task automatic finish_layer(input int n);
      bit seen = 1'b0;
      for (int t = 0; t < 200 && !seen; t++) begin
         @(negedge clk); #1;
         seen = done;
      end
      check("done seen", seen, 1'b1);
      @(negedge clk);
      @(negedge clk); #1;
      check("done pulses", done_total - done0, 1);
      if (n > 0) check("done after last write", done_cyc, last_wr_cyc + 1);
      else       check("done after start", done_cyc, start_cyc);
      check("write count", wr_total - wr0, n);
      check("scoreboard drained", exp_q.size(), 0);
      check("busy low after done", busy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset         = 1'b1;
      start         = 1'b0;
      base_addr     = '0;
      count         = '0;
      bus.acc_valid = 1'b0;
      bus.acc_data  = '0;
      bus.mem_stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs();
      reset = 1'b0;
      @(posedge clk); #1;

      // Basic layer: base 10, three results.
      vec[0] = 16'h0030; expv[0] = 8'h03;
      vec[1] = 16'h0100; expv[1] = 8'h10;
      vec[2] = 16'hFFE0; expv[2] = neg(8'hFE);
      start_layer(8'd10, 3);
      check("busy after start", busy, 1'b1);
      feed_vals(0, 3);
      finish_layer(3);
      check("no saturation basic", sat_flag, 1'b0);

      // Saturation at both rails.
      vec[0] = 16'h7FFF; expv[0] = 8'h7F;
      vec[1] = 16'h8000; expv[1] = neg(8'h80);
      start_layer(8'h30, 2);
      feed_vals(0, 2);
      finish_layer(2);
      check("sat_flag set", sat_flag, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("sat_flag sticky", sat_flag, 1'b1);

      // Backpressure: stall the write port while the FIFO fills.
      vec[0] = 16'h0010; expv[0] = 8'h01;
      vec[1] = 16'h0020; expv[1] = 8'h02;
      vec[2] = 16'hFFF0; expv[2] = neg(8'hFF);
      vec[3] = 16'h0070; expv[3] = 8'h07;
      vec[4] = 16'h07F0; expv[4] = 8'h7F;
      vec[5] = 16'hF800; expv[5] = neg(8'h80);
      vec[6] = 16'h0015; expv[6] = 8'h01;
      vec[7] = 16'hFFFF; expv[7] = neg(8'hFF);
      bus.mem_stall = 1'b1;
      start_layer(8'h50, 8);
      check("sat_flag cleared by start", sat_flag, 1'b0);
      feed_vals(0, 4);
      bus.acc_valid = 1'b1;
      bus.acc_data  = vec[4];
      repeat (4) begin
         @(posedge clk); #1;
         check("ready low when full", bus.acc_ready, 1'b0);
      end
      check("no writes while stalled", wr_total - wr0, 0);
      bus.mem_stall = 1'b0;
      feed_vals(4, 8);
      finish_layer(8);
      check("limit values do not saturate", sat_flag, 1'b0);

      // Address wrap.
      vec[0] = 16'h0040; expv[0] = 8'h04;
      vec[1] = 16'h0050; expv[1] = 8'h05;
      vec[2] = 16'h0060; expv[2] = 8'h06;
      start_layer(8'd254, 3);
      feed_vals(0, 3);
      finish_layer(3);

      // Zero count.
      start_layer(8'd5, 0);
      finish_layer(0);

      // Reset in the middle of a layer after two writes.
      vec[0] = 16'h0010; expv[0] = 8'h01;
      vec[1] = 16'h0020; expv[1] = 8'h02;
      vec[2] = 16'h0030; expv[2] = 8'h03;
      vec[3] = 16'h0040; expv[3] = 8'h04;
      vec[4] = 16'h0050; expv[4] = 8'h05;
      bus.mem_stall = 1'b1;
      start_layer(8'd40, 5);
      feed_vals(0, 4);
      bus.acc_valid = 1'b1;
      bus.acc_data  = vec[4];
      bus.mem_stall = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk); #1;
      check("writes before reset", wr_total - wr0, 2);
      reset = 1'b1;
      @(posedge clk); #1;
      bus.acc_valid = 1'b0;
      check_reset_outputs();
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Fresh layer after reset.
      vec[0] = 16'h0210; expv[0] = 8'h21;
      vec[1] = 16'hFE00; expv[1] = neg(8'hE0);
      start_layer(8'd20, 2);
      feed_vals(0, 2);
      finish_layer(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/neuron_writeback.md
# neuron_writeback

Write-side counterpart to the neuron read path. It accepts finished MAC accumulator results over a valid/ready handshake, rescales and saturates them to the neuron data width, and optionally applies ReLU. It buffers the results in a small FIFO and drives the write port of the neuron dual-port RAM at consecutive addresses from a base. When the programmed neuron count has been written, it reports completion to the layer controller.

## Interface
- ACC_W, 16, signed accumulator width from the MAC core
- DATA_W, 8, signed neuron value width stored in RAM
- ADDR_W, 8, neuron RAM address width
- FIFO_DEPTH, 4, result buffer entries (power of two, ≥2)
- FRAC_SHIFT, 4, arithmetic right shift applied to the accumulator
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; latches base_addr and count
- base_addr  in  ADDR_W  first write address of the layer
- count  in  ADDR_W  number of neurons to write (Nk)
- acc_valid  in  1  acc_data is valid
- acc_ready  out  1  block accepts acc_data this cycle
- acc_data  in  ACC_W  signed accumulator result
- mem_stall  in  1  write port busy; hold the FIFO head
- mem_wre  out  1  write enable to the neuron RAM
- mem_addr  out  ADDR_W  write address
- mem_data  out  DATA_W  write data
- busy  out  1  high from start until done
- done  out  1  one-cycle completion pulse
- sat_flag  out  1  sticky: some result saturated during the current layer

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on start.
  - IDLE → DONE on start with count=0.
  - RUN → DONE when the written count equals count.
  - DONE → IDLE unconditionally after 1 cycle.
- start in RUN or DONE is ignored. In IDLE, acc_ready=0.
- A sample is accepted when acc_valid && acc_ready.
- acc_ready = (state==RUN) && FIFO not full && accepted count < count. Samples beyond count are never accepted.
- Conversion happens at FIFO entry, in this order:
  1. s = acc_data >>> FRAC_SHIFT (sign-preserving).
  2. Clamp s to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. A clamp sets sat_flag.
  3. ReLU per Configuration.
- Drain: in any cycle with the FIFO non-empty and mem_stall=0, pop the head and register mem_wre=1, mem_addr = base + written_idx (mod 2^ADDR_W, wraps), mem_data = head.
- If no pop occurs, mem_wre=0 and mem_addr/mem_data hold their previous values.
- A simultaneous push and pop is legal, including with the FIFO full or empty-plus-push. An empty-plus-push pops no earlier than the next cycle.
- sat_flag clears on an accepted start.
- Reset at any time: FIFO flushed, counters zeroed, state IDLE.

## Timing
- Reset values:
  - acc_ready=0, mem_wre=0, mem_addr=0, mem_data=0, busy=0, done=0, sat_flag=0.
  - State IDLE, FIFO empty.
- A sample accepted at edge k appears with mem_wre=1 after edge k+1 if mem_stall=0 in cycle k+1. This is a 1-cycle FIFO-to-port latency.
- Sustained throughput is 1 write/cycle with no stalls.
- busy rises at the edge sampling start and falls with done.
- done is high for exactly the cycle following the last mem_wre cycle.
- For count=0, done is high in the cycle after the edge sampling start, and no writes occur.
- mem_stall raised in cycle c blocks the pop in cycle c. Backpressure reaches acc_ready once the FIFO holds FIFO_DEPTH entries.

## Configuration
- NEURON_WB_RELU_EN defined: after saturation, negative values are written as 0. sat_flag still reflects clamping only.
- Not defined: the saturated signed value is written unchanged.

## Structure
- Shared package `neuro_pkg` holds:
  - ACC_W, DATA_W, ADDR_W defaults
  - state encoding constants (IDLE, RUN, DONE)
  - saturation limit constants
- One sub-module: `sync_fifo`, parameterised by width and depth, with push/pop/full/empty.
- The FSM, counters, conversion logic and output registers live in `neuron_writeback`.

## Test plan
- Basic layer: base=10, count=3, FRAC_SHIFT=4, inputs 0x0030, 0x0100, 0xFFE0 → writes (10,0x03), (11,0x10), (12,0xFE). With NEURON_WB_RELU_EN, address 12 receives 0x00. done pulses once, in the cycle after the address-12 write.
- Saturation: inputs 0x7FFF, 0x8000 → data 0x7F, 0x80. sat_flag=1 until the next start.
- Backpressure: count=8, acc_valid held high, mem_stall=1 for 10 cycles → acc_ready drops after 4 accepts. After release, all 8 values are written in order at consecutive addresses.
- Wrap and zero count:
  - base=254, count=3 → addresses 254, 255, 0.
  - count=0 → done pulse one cycle after start, no mem_wre.
- Reset mid-run: reset asserted after 2 of 5 writes → every output returns to its reset value next cycle. A new start with base=20, count=2 then writes 20, 21 correctly.
